// File: rtl/dtfm_tx.sv
// dtfm_tx: DTFM link transmitter producing dCLK/dFM/dDAT for 64x10x16-bit frames, MSB first.
// Defining DTFM_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module dtfm_tx #(
    parameter int unsigned HALF_DIV = 16,
    parameter logic [15:0] PAD_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [3:0]  pl_idx,
    output logic        dCLK,
    output logic        dFM,
    output logic        dDAT,
    output logic        busy,
    output logic        underrun
`ifdef DTFM_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]  underrun_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_div;
    logic        r_dclk, r_fm, r_und, r_full;
    logic [3:0]  r_bit, r_word, r_idx;
    logic [5:0]  r_str;
    logic [8:0]  r_frm;
    logic [15:0] r_shift, r_hold;
    logic        w_tick, w_fall, w_word_end, w_frame_end, w_acc;
    logic        w_start, w_to_idle, w_load, w_slot, w_und;
    logic [3:0]  w_nword, w_lword;
    logic [5:0]  w_nstr, w_lstr;
    logic [8:0]  w_nfrm, w_lfrm;
    logic [15:0] w_hdr;

    assign w_tick      = (r_state != IDLE) && (r_div == 8'(HALF_DIV - 1));
    assign w_fall      = w_tick && r_dclk;
    assign w_word_end  = w_fall && (r_bit == 4'd15);
    assign w_frame_end = w_word_end && (r_word == 4'd9) && (r_str == 6'd63);
    assign w_nword     = (r_word == 4'd9) ? 4'd0 : r_word + 4'd1;
    assign w_nstr      = (r_word == 4'd9) ? r_str + 6'd1 : r_str;
    assign w_nfrm      = (r_word == 4'd9 && r_str == 6'd63) ? r_frm + 9'd1 : r_frm;
    assign w_acc       = pl_valid && !r_full;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_to_idle = 1'b0;
        if (r_state == IDLE) begin
            w_next  = run ? RUN : IDLE;
            w_start = run;
        end else if (run)
            w_next = RUN;
        else if (r_state == RUN || !w_frame_end)
            w_next = STOP;
        else begin
            w_next    = IDLE;
            w_to_idle = 1'b1;
        end
        // a start reloads the current counters; otherwise the word after the one just finished
        w_load  = w_start || (w_word_end && !w_to_idle);
        w_lword = w_start ? r_word : w_nword;
        w_lstr  = w_start ? r_str : w_nstr;
        w_lfrm  = w_start ? r_frm : w_nfrm;
        w_hdr   = {w_lfrm, w_lstr, ~w_lstr[0]};
        w_slot  = w_load && (w_lword != 4'd0);
        w_und   = w_slot && !r_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_dclk  <= 1'b0;
            r_fm    <= 1'b0;
            r_und   <= 1'b0;
            r_full  <= 1'b0;
            r_bit   <= '0;
            r_word  <= '0;
            r_idx   <= 4'd1;
            r_str   <= '0;
            r_frm   <= '0;
            r_shift <= '0;
            r_hold  <= '0;
        end else begin
            r_und  <= w_und;
            r_div  <= (r_state == IDLE || w_tick) ? 8'd0 : r_div + 8'd1;
            r_dclk <= (r_state == IDLE) ? 1'b0 : r_dclk ^ w_tick;
            // the 16th shift empties the shifter, so dDAT idles low after the last bit
            if (w_fall) begin
                r_bit   <= r_bit + 4'd1;
                r_shift <= {r_shift[14:0], 1'b0};
                r_fm    <= 1'b0;
            end
            if (w_word_end) begin
                r_word <= w_nword;
                r_str  <= w_nstr;
                r_frm  <= w_nfrm;
            end
            if (w_load) begin
                r_shift <= w_slot ? (r_full ? r_hold : PAD_WORD) : w_hdr;
                r_fm    <= !w_slot && (w_lstr == 6'd0);
            end
            if (w_slot) begin
                r_idx  <= (r_idx == 4'd9) ? 4'd1 : r_idx + 4'd1;
                r_full <= 1'b0;
            end
            // an accept on the load clk refills the register after the old word moved out
            if (w_acc) begin
                r_hold <= pl_data;
                r_full <= 1'b1;
            end
        end
    end

    assign pl_ready = !r_full;
    assign pl_idx   = r_idx;
    assign dCLK     = r_dclk;
    assign dFM      = r_fm;
    assign dDAT     = r_shift[15];
    assign busy     = (r_state != IDLE);
    assign underrun = r_und;

`ifdef DTFM_TX_UNDERRUN_CNT_EN
    logic [7:0] r_ucnt;

    always_ff @(posedge clk) begin
        if (reset || w_start)
            r_ucnt <= '0;
        else if (w_und && r_ucnt != 8'hFF)
            r_ucnt <= r_ucnt + 8'd1;
    end

    assign underrun_cnt = r_ucnt;
`endif
endmodule

// File: tb/tb_dtfm_tx.sv
// tb_dtfm_tx: directed bench for dtfm_tx at HALF_DIV = 2, decoding the serial line into words.
`timescale 1ns/1ps
module tb_dtfm_tx;
    localparam int HD = 2;

    logic        clk = 1'b0, reset = 1'b1, run = 1'b0, pl_valid = 1'b0;
    logic [15:0] pl_data = 16'h1000;
    logic        pl_ready, dCLK, dFM, dDAT, busy, underrun;
    logic [3:0]  pl_idx;
`ifdef DTFM_TX_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif
    logic        host_en = 1'b0, gap_en = 1'b0, fire;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    dtfm_tx #(.HALF_DIV(HD), .PAD_WORD(16'h0000)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .pl_data(pl_data),
        .pl_valid(pl_valid),
        .pl_ready(pl_ready),
        .pl_idx(pl_idx),
        .dCLK(dCLK),
        .dFM(dFM),
        .dDAT(dDAT),
        .busy(busy),
        .underrun(underrun)
`ifdef DTFM_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    // host: incrementing data, optionally withholding slots 3 and 4
    initial begin
        forever begin
            @(posedge clk);
            fire = pl_valid && pl_ready && !reset;
            #1;
            if (fire)
                pl_data = pl_data + 16'd1;
            pl_valid = host_en && !(gap_en && (pl_idx == 4'd3 || pl_idx == 4'd4));
        end
    end

    // line decoder and timing monitors
    logic [15:0] words[$];
    logic        fms[$];
    int          fm_rise_at[$];
    int          cyc = 0, rises = 0, fm_hi = 0, und_pulses = 0, viol_d = 0, viol_p = 0;
    int          last_rise = 0, bitcnt = 0;
    logic        lr_valid = 1'b0, fm_cur = 1'b0, pc = 1'b0, pd = 1'b0, pb = 1'b0;
    logic [15:0] sh = '0;

    always @(negedge clk) begin
        cyc++;
        if (dFM)
            fm_hi++;
        if (underrun)
            und_pulses++;
        if (dDAT !== pd && pb && busy && !(pc && !dCLK))
            viol_d++;
        if (!pc && dCLK)
            rises++;
        if (!busy) begin
            bitcnt   = 0;
            lr_valid = 1'b0;
        end else if (!pc && dCLK) begin
            if (lr_valid && cyc - last_rise != 2 * HD)
                viol_p++;
            last_rise = cyc;
            lr_valid  = 1'b1;
            if (bitcnt == 0) begin
                fm_cur = dFM;
                if (dFM)
                    fm_rise_at.push_back(rises);
            end
            sh = {sh[14:0], dDAT};
            bitcnt++;
            if (bitcnt == 16) begin
                words.push_back(sh);
                fms.push_back(fm_cur);
                bitcnt = 0;
            end
        end else if (pc && !dCLK && lr_valid && cyc - last_rise != HD)
            viol_p++;
        pc = dCLK;
        pd = dDAT;
        pb = busy;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 95000 clk");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int i = 0;
        while (words.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk($sformatf("wait_words_%0d", n), words.size() >= n, 1);
    endtask

    task automatic wait_und(input int n, input int budget);
        int i = 0;
        while (und_pulses < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk($sformatf("wait_underrun_%0d", n), und_pulses >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_bit(input int n, input int budget);
        int i = 0;
        while (bitcnt != n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_bit", bitcnt, n);
    endtask

    // expected word k of the first frame: slots 3 and 4 of string 0 padded
    function automatic logic [15:0] exp_w0(input int k);
        int         s = k / 10, slot = k % 10, p;
        logic [5:0] sv;
        sv = s[5:0];
        if (slot == 0)
            return {9'd0, sv, ~sv[0]};
        p = s * 9 + slot - 1;
        if (p == 2 || p == 3)
            return 16'h0000;
        return 16'(32'h1000 + p - (p >= 4 ? 2 : 0));
    endfunction

    typedef struct {
        int          idx;
        logic [15:0] w;
        logic        fm;
    } vec_t;
    vec_t tv[12];

    initial begin
        int errs, r0, base;
        int u0;
        tv[0]  = '{0,   16'h0001, 1'b1};
        tv[1]  = '{1,   16'h1000, 1'b0};
        tv[2]  = '{2,   16'h1001, 1'b0};
        tv[3]  = '{3,   16'h0000, 1'b0};
        tv[4]  = '{4,   16'h0000, 1'b0};
        tv[5]  = '{5,   16'h1002, 1'b0};
        tv[6]  = '{9,   16'h1006, 1'b0};
        tv[7]  = '{10,  16'h0002, 1'b0};
        tv[8]  = '{11,  16'h1007, 1'b0};
        tv[9]  = '{100, 16'h0015, 1'b0};
        tv[10] = '{630, 16'h007E, 1'b0};
        tv[11] = '{639, 16'h123D, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_dclk", dCLK, 0);
        chk("rst_dfm", dFM, 0);
        chk("rst_ddat", dDAT, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_pl_ready", pl_ready, 1);
        chk("rst_pl_idx", pl_idx, 1);

        gap_en  = 1'b1;
        host_en = 1'b1;
        run     = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        wait_und(2, 2000);
        chk("pl_idx_after_pad", pl_idx, 5);
        gap_en = 1'b0;

        wait_words(105, 8000);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_in_stop", busy, 1);
        wait_words(205, 8000);
        run = 1'b1;
        wait_words(305, 8000);
        run = 1'b0;
        wait_idle(30000);

        chk("frame_words", words.size(), 640);
        chk("frame_rises", rises, 10240);
        chk("fm_high_clks", fm_hi, 4 * 1 * HD * 2 / 4);
        chk("underrun_pulses", und_pulses, 2);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("word_%0d", tv[i].idx),
                tv[i].idx < words.size() ? 32'(words[tv[i].idx]) : 32'hDEADBEEF, 32'(tv[i].w));
            chk($sformatf("fm_%0d", tv[i].idx),
                tv[i].idx < fms.size() ? 32'(fms[tv[i].idx]) : 32'hDEADBEEF, 32'(tv[i].fm));
        end
        errs = 0;
        for (int k = 0; k < 640 && k < words.size(); k++)
            if (words[k] !== exp_w0(k) || fms[k] !== (k == 0))
                errs++;
        chk("stream_frame0", errs, 0);

        r0 = rises;
        repeat (100) @(negedge clk);
        chk("idle_no_edges", rises - r0, 0);
        chk("idle_dclk", dCLK, 0);
        chk("idle_ddat", dDAT, 0);

        run = 1'b1;
        wait_words(641, 2000);
        chk("hdr_frame1", words.size() > 640 ? 32'(words[640]) : 32'hDEADBEEF, 32'h0081);
        chk("fm_frame1", fms.size() > 640 ? 32'(fms[640]) : 32'hDEADBEEF, 1);
        chk("fm_spacing", fm_rise_at.size() >= 2 ? fm_rise_at[1] - fm_rise_at[0] : -1, 10240);

        wait_words(642, 2000);
        wait_bit(7, 200);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_dclk", dCLK, 0);
        chk("abort_dfm", dFM, 0);
        chk("abort_ddat", dDAT, 0);
        chk("abort_pl_ready", pl_ready, 1);
        chk("abort_pl_idx", pl_idx, 1);
        chk("abort_busy", busy, 0);
        reset = 1'b0;
        base  = words.size();
        wait_words(base + 2, 2000);
        chk("hdr_restart", words.size() > base ? 32'(words[base]) : 32'hDEADBEEF, 32'h0001);
        chk("fm_restart", fms.size() > base ? 32'(fms[base]) : 32'hDEADBEEF, 1);

`ifdef DTFM_TX_UNDERRUN_CNT_EN
        chk("ucnt_cleared", underrun_cnt, 0);
        u0      = und_pulses;
        host_en = 1'b0;
        wait_und(u0 + 100, 10000);
        chk("ucnt_100", underrun_cnt, 100);
        wait_und(u0 + 300, 25000);
        chk("ucnt_saturated", underrun_cnt, 255);
`else
        u0 = und_pulses;
        chk("no_underrun_restart", und_pulses - u0, 0);
`endif

        chk("dclk_timing", viol_p, 0);
        chk("ddat_stable", viol_d, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
